// File: rtl/id_issue_queue_pkg.sv
// Shared definitions for the decode-side issue queue.
// Contents:
//   - Layout of one forwarding source on fwd_bus.
//   - Register-field positions within an instruction.
//   - The hard-wired zero register address.
package id_issue_queue_pkg;

    // One forwarding source: {we, waddr, wdata}, 38 bits, with source 0 in the LSBs of fwd_bus.
    localparam int FWD_WD = 38;
    localparam int REG_W  = 5;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] waddr;
        logic [31:0]      wdata;
    } fwd_src_t;

endpackage

// File: rtl/id_issue_queue_if.sv
// Fetch-side and issue-side handshake bundle of the issue queue.
// Modports:
//   master - the environment. It drives if_* and issue_ready, and observes issue_*.
//   slave  - the queue. It accepts fetched {pc,inst} and presents the head for issue.
interface id_issue_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              issue_valid;
    logic              issue_ready;
    logic [PC_W-1:0]   issue_pc;
    logic [INST_W-1:0] issue_inst;
    logic [31:0]       issue_rdata1;
    logic [31:0]       issue_rdata2;

    modport master (
        output if_valid, if_pc, if_inst, issue_ready,
        input  if_ready, issue_valid, issue_pc, issue_inst, issue_rdata1, issue_rdata2
    );

    modport slave (
        input  if_valid, if_pc, if_inst, issue_ready,
        output if_ready, issue_valid, issue_pc, issue_inst, issue_rdata1, issue_rdata2
    );
endinterface

// File: rtl/id_issue_queue_fifo_ptr.sv
// id_fifo_ptr: circular {pc,inst} store for the issue queue.
// It holds the storage array, the read/write pointers, occupancy, full/empty,
// and the rule for which entry survives a branch flush.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   push, pop            - qualified enqueue and dequeue strobes
//   flush                - taken branch this cycle
//   wr_pc, wr_inst       - entry to enqueue
//   head_pc, head_inst   - oldest stored entry (only meaningful when !empty)
//   empty, full          - status flags, derived from registered occupancy
//   occupancy            - number of valid entries
module id_fifo_ptr #(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 32,
    parameter int INST_W     = 32,
    parameter int DELAY_SLOT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [PC_W-1:0]          wr_pc,
    input  logic [INST_W-1:0]        wr_inst,
    output logic [PC_W-1:0]          head_pc,
    output logic [INST_W-1:0]        head_inst,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PC_W-1:0]   mem_pc_r   [DEPTH];
    logic [INST_W-1:0] mem_inst_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              keep_stored_s;

    // Next pointers and occupancy, including the flush-keep selection.
    always_comb begin
        rd_ptr_s      = rd_ptr_r;
        wr_ptr_s      = wr_ptr_r;
        count_s       = count_r;
        keep_stored_s = 1'b0;
        if (flush) begin
            if (DELAY_SLOT != 0) begin
                // The delay slot is the oldest stored entry that is not leaving via this cycle's pop.
                if (pop) begin
                    keep_stored_s = (count_r >= CNT_TWO);
                end else begin
                    keep_stored_s = (count_r >= CNT_ONE);
                end
                if (keep_stored_s) begin
                    rd_ptr_s = pop ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
                    wr_ptr_s = rd_ptr_s + PTR_ONE;
                    count_s  = CNT_ONE;
                end else if (push) begin
                    // The incoming entry lands at wr_ptr_r and becomes the delay slot.
                    rd_ptr_s = wr_ptr_r;
                    wr_ptr_s = wr_ptr_r + PTR_ONE;
                    count_s  = CNT_ONE;
                end else begin
                    rd_ptr_s = wr_ptr_r;
                    wr_ptr_s = wr_ptr_r;
                    count_s  = {CNT_W{1'b0}};
                end
            end else begin
                rd_ptr_s = wr_ptr_r;
                wr_ptr_s = wr_ptr_r;
                count_s  = {CNT_W{1'b0}};
            end
        end else begin
            if (pop) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (push) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_s;
            wr_ptr_r <= wr_ptr_s;
            count_r  <= count_s;
        end
    end

    // Entry storage. A write of a dropped push during a flush is harmless because the pointers exclude it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_r[i]   <= {PC_W{1'b0}};
                mem_inst_r[i] <= {INST_W{1'b0}};
            end
        end else if (push) begin
            mem_pc_r[wr_ptr_r]   <= wr_pc;
            mem_inst_r[wr_ptr_r] <= wr_inst;
        end
    end

    assign head_pc   = mem_pc_r[rd_ptr_r];
    assign head_inst = mem_inst_r[rd_ptr_r];
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_MAX);
    assign occupancy = count_r;
endmodule

// File: rtl/id_issue_queue.sv
// id_issue_queue: decode-side instruction queue between IF and decode/EX.
// It buffers fetched {pc,inst} pairs and resolves the head's rs/rt operands
// through a prioritised forwarding network (source 0 = youngest, highest priority).
// It withholds issue on a load-use hazard against the instruction in EX.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   q (slave)         - IF push handshake and issue handshake with head pc/inst/operands
//   flush             - taken branch/jump resolved this cycle
//   ex_is_load        - instruction in EX is a load
//   fwd_bus           - NUM_FWD sources of {we,waddr,wdata}, with source 0 in the LSBs
//   rf_raddr1/2       - register file read addresses (head rs/rt)
//   rf_rdata1/2       - register file read data, used when no source forwards
//   occupancy         - valid entries
//   stall_cnt         - saturating count of load-use stall cycles
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 32,
    parameter int INST_W     = 32,
    parameter int NUM_FWD    = 3,
    parameter int DELAY_SLOT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    id_issue_queue_if.slave            q,
    input  logic                       flush,
    input  logic                       ex_is_load,
    input  logic [NUM_FWD*FWD_WD-1:0]  fwd_bus,
    output logic [REG_W-1:0]           rf_raddr1,
    output logic [REG_W-1:0]           rf_raddr2,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                stall_cnt
);
    logic              push_s, pop_s, empty_s, full_s, head_valid_s, hazard_s;
    logic [PC_W-1:0]   head_pc_s;
    logic [INST_W-1:0] head_inst_s;
    logic [REG_W-1:0]  rs_s, rt_s;
    fwd_src_t          fwd0_s;
    logic [31:0]       stall_cnt_r;

    // Scan from the highest index down, so the lowest matching source ends up winning. r0 always reads as zero.
    function automatic logic [31:0] fwd_select(input logic [REG_W-1:0] addr,
                                               input logic [NUM_FWD*FWD_WD-1:0] bus,
                                               input logic [31:0] rf_data);
        fwd_src_t    src;
        logic [31:0] res;
        res = rf_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            src = bus[i*FWD_WD +: FWD_WD];
            if (src.we && (src.waddr == addr)) begin
                res = src.wdata;
            end else begin
                res = res;
            end
        end
        if (addr == REG_ZERO) begin
            res = 32'h0000_0000;
        end else begin
            res = res;
        end
        return res;
    endfunction

    id_fifo_ptr #(
        .DEPTH      (DEPTH),
        .PC_W       (PC_W),
        .INST_W     (INST_W),
        .DELAY_SLOT (DELAY_SLOT)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush),
        .wr_pc     (q.if_pc),
        .wr_inst   (q.if_inst),
        .head_pc   (head_pc_s),
        .head_inst (head_inst_s),
        .empty     (empty_s),
        .full      (full_s),
        .occupancy (occupancy)
    );

    // Head register fields. They are forced to r0 when the queue is empty, so an empty queue cannot raise a hazard.
    always_comb begin
        head_valid_s = !empty_s;
        if (head_valid_s) begin
            rs_s = head_inst_s[RS_LSB +: REG_W];
            rt_s = head_inst_s[RT_LSB +: REG_W];
        end else begin
            rs_s = REG_ZERO;
            rt_s = REG_ZERO;
        end
    end

    assign fwd0_s   = fwd_bus[FWD_WD-1:0];
    assign hazard_s = ex_is_load && fwd0_s.we && (fwd0_s.waddr != REG_ZERO) &&
                      ((fwd0_s.waddr == rs_s) || (fwd0_s.waddr == rt_s));

    assign q.if_ready    = !full_s;
    assign q.issue_valid = head_valid_s && !hazard_s;
    assign push_s        = q.if_valid && !full_s;
    assign pop_s         = q.issue_valid && q.issue_ready;
    assign rf_raddr1     = rs_s;
    assign rf_raddr2     = rt_s;

    // Issue payload: the head with forwarded operands, or all zeros when the queue is empty.
    always_comb begin
        q.issue_pc     = {PC_W{1'b0}};
        q.issue_inst   = {INST_W{1'b0}};
        q.issue_rdata1 = 32'h0000_0000;
        q.issue_rdata2 = 32'h0000_0000;
        if (head_valid_s) begin
            q.issue_pc     = head_pc_s;
            q.issue_inst   = head_inst_s;
            q.issue_rdata1 = fwd_select(rs_s, fwd_bus, rf_rdata1);
            q.issue_rdata2 = fwd_select(rt_s, fwd_bus, rf_rdata2);
        end else begin
            q.issue_pc     = {PC_W{1'b0}};
            q.issue_inst   = {INST_W{1'b0}};
            q.issue_rdata1 = 32'h0000_0000;
            q.issue_rdata2 = 32'h0000_0000;
        end
    end

    // Load-use stall counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (head_valid_s && hazard_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue. Instance dut keeps the delay slot on flush;
// instance dut_nd (DELAY_SLOT=0) sees the same stimulus and clears on flush.
module tb_id_issue_queue;
    import id_issue_queue_pkg::*;

    localparam int NUM_FWD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, issue_ready, flush, ex_is_load;
    logic [31:0] if_pc, if_inst, rf_rdata1, rf_rdata2;
    logic [NUM_FWD*FWD_WD-1:0] fwd_bus;
    logic [4:0]  ra1_a, ra2_a, ra1_b, ra2_b;
    logic [2:0]  occ_a, occ_b;
    logic [31:0] stall_a, stall_b;

    int n_checks = 0;
    int n_pass   = 0;

    id_issue_queue_if qa ();
    id_issue_queue_if qb ();

    assign qa.if_valid    = if_valid;
    assign qa.if_pc       = if_pc;
    assign qa.if_inst     = if_inst;
    assign qa.issue_ready = issue_ready;
    assign qb.if_valid    = if_valid;
    assign qb.if_pc       = if_pc;
    assign qb.if_inst     = if_inst;
    assign qb.issue_ready = issue_ready;

    id_issue_queue #(.DELAY_SLOT(1)) dut (
        .clk(clk), .rst(rst), .q(qa), .flush(flush), .ex_is_load(ex_is_load),
        .fwd_bus(fwd_bus), .rf_raddr1(ra1_a), .rf_raddr2(ra2_a),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .occupancy(occ_a), .stall_cnt(stall_a)
    );

    id_issue_queue #(.DELAY_SLOT(0)) dut_nd (
        .clk(clk), .rst(rst), .q(qb), .flush(flush), .ex_is_load(ex_is_load),
        .fwd_bus(fwd_bus), .rf_raddr1(ra1_b), .rf_raddr2(ra2_b),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .occupancy(occ_b), .stall_cnt(stall_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge and are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [37:0] src(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'h0000};
    endfunction

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        tick();
        if_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = 32'h0; if_inst = 32'h0;
        issue_ready = 1'b0; flush = 1'b0; ex_is_load = 1'b0; fwd_bus = '0;
        rf_rdata1 = 32'h55; rf_rdata2 = 32'h66;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_if_ready", qa.if_ready, 1);
        check("rst_issue_valid", qa.issue_valid, 0);
        check("rst_occupancy", occ_a, 0);
        check("rst_stall_cnt", stall_a, 0);
        check("rst_raddr1", ra1_a, 0);
        check("rst_issue_pc", qa.issue_pc, 0);
        check("rst_rdata1", qa.issue_rdata1, 0);

        // Fill with no consumer: only four of five are stored.
        for (int i = 0; i < 5; i++) begin
            if_valid = 1'b1; if_pc = 32'h10 + 32'(4 * i); if_inst = mk_inst(5'd1, 5'd2);
            #1;
            check("fill_if_ready", qa.if_ready, (i < 4) ? 1 : 0);
            tick();
        end
        if_valid = 1'b0;
        #1;
        check("fill_occupancy", occ_a, 4);
        check("fill_if_ready_full", qa.if_ready, 0);
        check("fill_head_pc", qa.issue_pc, 32'h10);
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", qa.issue_valid, 1);
            check("drain_pc", qa.issue_pc, 32'h10 + 32'(4 * i));
            if (i == 0) check("full_pop_no_reopen", qa.if_ready, 0);
            tick();
        end
        #1;
        check("drain_empty_valid", qa.issue_valid, 0);
        check("drain_empty_occ", occ_a, 0);
        check("drain_empty_pc", qa.issue_pc, 0);

        // Ordering, one-cycle latency, push+pop keeps occupancy.
        if_valid = 1'b1; if_pc = 32'h100; if_inst = mk_inst(5'd1, 5'd2);
        #1;
        check("no_bypass", qa.issue_valid, 0);
        tick();
        if_pc = 32'h104;
        #1;
        check("order_pc0", qa.issue_pc, 32'h100);
        check("pushpop_occ0", occ_a, 1);
        tick();
        if_pc = 32'h108;
        #1;
        check("order_pc1", qa.issue_pc, 32'h104);
        check("pushpop_occ1", occ_a, 1);
        tick();
        if_valid = 1'b0;
        #1;
        check("order_pc2", qa.issue_pc, 32'h108);
        tick();
        #1;
        check("order_empty", qa.issue_valid, 0);

        // Load-use interlock for two cycles.
        push_one(32'h300, mk_inst(5'd5, 5'd9));
        ex_is_load = 1'b1;
        fwd_bus = {src(1'b0, 5'd0, 32'h0), src(1'b0, 5'd0, 32'h0), src(1'b1, 5'd5, 32'h1234)};
        #1;
        check("lu_stall0", qa.issue_valid, 0);
        check("lu_raddr1", ra1_a, 5);
        tick();
        #1;
        check("lu_stall1", qa.issue_valid, 0);
        tick();
        ex_is_load = 1'b0;
        #1;
        check("lu_stall_cnt", stall_a, 2);
        check("lu_release", qa.issue_valid, 1);
        check("lu_fwd_rdata1", qa.issue_rdata1, 32'h1234);
        tick();
        fwd_bus = '0;
        #1;
        check("lu_popped", occ_a, 0);

        // Forwarding priority and fallback.
        issue_ready = 1'b0;
        push_one(32'h400, mk_inst(5'd3, 5'd7));
        rf_rdata1 = 32'h1111; rf_rdata2 = 32'hCCCC;
        fwd_bus = {src(1'b1, 5'd7, 32'hBBBB), src(1'b0, 5'd0, 32'h0), src(1'b1, 5'd7, 32'hAAAA)};
        #1;
        check("fwd_src0_wins", qa.issue_rdata2, 32'hAAAA);
        check("fwd_raddr2", ra2_a, 7);
        check("fwd_rs_from_rf", qa.issue_rdata1, 32'h1111);
        fwd_bus = {src(1'b1, 5'd7, 32'hBBBB), src(1'b0, 5'd0, 32'h0), src(1'b0, 5'd7, 32'hAAAA)};
        #1;
        check("fwd_src2", qa.issue_rdata2, 32'hBBBB);
        fwd_bus = {src(1'b0, 5'd7, 32'hBBBB), src(1'b0, 5'd0, 32'h0), src(1'b1, 5'd8, 32'hAAAA)};
        #1;
        check("fwd_no_match", qa.issue_rdata2, 32'hCCCC);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Zero register is never forwarded and never interlocks.
        push_one(32'h410, mk_inst(5'd0, 5'd7));
        ex_is_load = 1'b1;
        rf_rdata1 = 32'h2222;
        fwd_bus = {src(1'b0, 5'd0, 32'h0), src(1'b0, 5'd0, 32'h0), src(1'b1, 5'd0, 32'hFFFF)};
        #1;
        check("zero_reg_rdata1", qa.issue_rdata1, 0);
        check("zero_reg_no_hazard", qa.issue_valid, 1);
        issue_ready = 1'b1;
        tick();
        ex_is_load = 1'b0; fwd_bus = '0; issue_ready = 1'b0;

        // Flush: pop 0x200, push 0x20C; delay slot 0x204 survives only with DELAY_SLOT=1.
        push_one(32'h200, mk_inst(5'd1, 5'd2));
        push_one(32'h204, mk_inst(5'd1, 5'd2));
        push_one(32'h208, mk_inst(5'd1, 5'd2));
        issue_ready = 1'b1; flush = 1'b1; if_valid = 1'b1; if_pc = 32'h20C;
        #1;
        check("flush_pop_head", qa.issue_pc, 32'h200);
        tick();
        flush = 1'b0; if_valid = 1'b0; issue_ready = 1'b0;
        #1;
        check("flush_ds_occ", occ_a, 1);
        check("flush_ds_pc", qa.issue_pc, 32'h204);
        check("flush_nd_occ", occ_b, 0);
        check("flush_nd_valid", qb.issue_valid, 0);

        // Flush when the last stored entry is popped: the same-cycle push becomes the kept entry.
        issue_ready = 1'b1; flush = 1'b1; if_valid = 1'b1; if_pc = 32'h500;
        tick();
        flush = 1'b0; if_valid = 1'b0; issue_ready = 1'b0;
        #1;
        check("flush_keep_push_occ", occ_a, 1);
        check("flush_keep_push_pc", qa.issue_pc, 32'h500);
        check("flush_nd_drop_push", occ_b, 0);

        // Reset with entries in flight.
        push_one(32'h600, mk_inst(5'd1, 5'd2));
        push_one(32'h604, mk_inst(5'd1, 5'd2));
        push_one(32'h608, mk_inst(5'd1, 5'd2));
        #1;
        check("pre_rst_occ_nd", occ_b, 3);
        check("pre_rst_stall", stall_a, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_occ", occ_a, 0);
        check("mid_rst_occ_nd", occ_b, 0);
        check("mid_rst_valid", qa.issue_valid, 0);
        check("mid_rst_stall", stall_a, 0);
        check("mid_rst_if_ready", qa.if_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
